// File: rtl/card_flip_ctrl_pkg.sv
// Shared game defines: FSM state encodings, board defaults and small helpers
// used by the card-flip memory game controller.
package card_flip_ctrl_pkg;

    // Board defaults: 16 tiles, 3-bit face ids (8 pairs), 60 frames of reveal.
    localparam int N_CARDS_DEF     = 16;
    localparam int FACE_W_DEF      = 3;
    localparam int SHOW_FRAMES_DEF = 60;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FIRST  = 3'd1;
    localparam logic [2:0] ST_SECOND = 3'd2;
    localparam logic [2:0] ST_SHOW   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // The move counter sticks at 255 rather than wrapping back to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/card_flip_ctrl_vsync_tick.sv
// Frame-tick generator: turns the VGA vertical sync level into a one-cycle
// pulse on its rising edge. Shared by any block that counts frames.
module vsync_tick (
    input  logic pclk,
    input  logic rst,
    input  logic vs_in,
    output logic tick
);

    logic vs_in_q;

    // Delay vsync by one pixel clock so its rising edge can be detected.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_in_q <= 1'b0;
        end else begin
            vs_in_q <= vs_in;
        end
    end

    assign tick = vs_in & ~vs_in_q;

endmodule

// File: rtl/card_flip_ctrl.sv
// Card-flip memory game controller. Tracks which tiles are face up or already
// matched, scores the two-pick attempts, and holds a mismatched pair visible
// for a fixed number of video frames before turning it back over.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | after reset; waits for start, ignores picks and frame ticks
//   FIRST  | waiting for the first tile of an attempt
//   SECOND | first tile is face up; waiting for the second tile
//   SHOW   | mismatched pair visible; counting frames, picks ignored
//   DONE   | every pair found; outputs frozen until the next start
module card_flip_ctrl
    import card_flip_ctrl_pkg::*;
#(
    parameter int N_CARDS     = N_CARDS_DEF,
    parameter int FACE_W      = FACE_W_DEF,
    parameter int SHOW_FRAMES = SHOW_FRAMES_DEF
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic                      vs_in,
    input  logic                      start,
    input  logic [N_CARDS*FACE_W-1:0] card_face,
    input  logic                      pick_valid,
    input  logic [3:0]                pick_idx,
    output logic [N_CARDS-1:0]        face_up,
    output logic [N_CARDS-1:0]        matched,
    output logic [3:0]                pairs_found,
    output logic [7:0]                moves,
    output logic                      busy,
    output logic                      game_done
);

    localparam int                TMR_W     = $clog2(SHOW_FRAMES + 1);
    localparam logic [TMR_W-1:0]  TMR_END   = TMR_W'(SHOW_FRAMES);
    localparam logic [3:0]        PAIRS_ALL = 4'(N_CARDS / 2);

    logic [2:0]                  state;
    logic [TMR_W-1:0]            timer;
    logic [N_CARDS*FACE_W-1:0]   face_lat;
    logic [3:0]                  first_idx;
    logic [3:0]                  second_idx;

    logic                        tick;
    logic [31:0]                 idx_ext;
    logic                        idx_in_range;
    logic [N_CARDS-1:0]          pick_mask;
    logic [N_CARDS-1:0]          first_mask;
    logic [N_CARDS-1:0]          second_mask;
    logic                        tile_free;
    logic                        pick_ok;
    logic [FACE_W-1:0]           first_face;
    logic [FACE_W-1:0]           pick_face;
    logic                        is_match;
    logic [3:0]                  pairs_nx;

    vsync_tick u_vsync_tick (
        .pclk  (pclk),
        .rst   (rst),
        .vs_in (vs_in),
        .tick  (tick)
    );

    // Decode the pick into a tile mask; out-of-range indices give an empty
    // mask so the board vectors are never indexed past N_CARDS.
    always_comb begin
        idx_ext      = 32'(pick_idx);
        idx_in_range = (idx_ext < 32'(N_CARDS));
        pick_mask    = idx_in_range ? (N_CARDS'(1) << pick_idx) : '0;
        first_mask   = N_CARDS'(1) << first_idx;
        second_mask  = N_CARDS'(1) << second_idx;
        tile_free    = idx_in_range && ((pick_mask & (face_up | matched)) == '0);
        // start takes priority over a pick arriving in the same cycle.
        pick_ok      = pick_valid && !start && tile_free &&
                       ((state == ST_FIRST) || (state == ST_SECOND));
        pairs_nx     = pairs_found + 4'd1;
    end

    // Look up the latched faces of the first tile and the tile being picked.
    always_comb begin
        first_face = '0;
        pick_face  = '0;
        for (int i = 0; i < N_CARDS; i++) begin
            if (first_idx == 4'(i)) begin
                first_face = face_lat[i*FACE_W +: FACE_W];
            end
            if (pick_idx == 4'(i)) begin
                pick_face = face_lat[i*FACE_W +: FACE_W];
            end
        end
        is_match = (first_face == pick_face);
    end

    // Game FSM with board state, scoring and the reveal timer.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            face_lat    <= '0;
            first_idx   <= 4'd0;
            second_idx  <= 4'd0;
            face_up     <= '0;
            matched     <= '0;
            pairs_found <= 4'd0;
            moves       <= 8'd0;
        end else if (start) begin
            state       <= ST_FIRST;
            timer       <= '0;
            face_lat    <= card_face;
            first_idx   <= 4'd0;
            second_idx  <= 4'd0;
            face_up     <= '0;
            matched     <= '0;
            pairs_found <= 4'd0;
            moves       <= 8'd0;
        end else begin
            case (state)
                ST_FIRST: begin
                    if (pick_ok) begin
                        face_up   <= face_up | pick_mask;
                        first_idx <= pick_idx;
                        state     <= ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (pick_ok) begin
                        second_idx <= pick_idx;
                        moves      <= sat_inc8(moves);
                        if (is_match) begin
                            // Matched tiles leave the face-up set; the
                            // matched vector keeps them drawn from now on.
                            matched     <= matched | first_mask | pick_mask;
                            face_up     <= face_up & ~first_mask;
                            pairs_found <= pairs_nx;
                            state       <= (pairs_nx == PAIRS_ALL) ? ST_DONE : ST_FIRST;
                        end else begin
                            face_up <= face_up | pick_mask;
                            timer   <= '0;
                            state   <= ST_SHOW;
                        end
                    end
                end
                ST_SHOW: begin
                    if (timer == TMR_END) begin
                        face_up <= face_up & ~(first_mask | second_mask);
                        state   <= ST_FIRST;
                    end else if (tick) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == ST_SHOW);
    assign game_done = (state == ST_DONE);

endmodule

// File: tb/tb_card_flip_ctrl.sv
// Self-checking bench for card_flip_ctrl: directed game scenarios plus a
// randomized phase, all compared every cycle against a behavioural model of
// the game rules kept in this file.
module tb_card_flip_ctrl;

    localparam int NC = 16;
    localparam int SF = 60;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        vs_in = 1'b0;
    logic        start = 1'b0;
    logic [47:0] card_face = '0;
    logic        pick_valid = 1'b0;
    logic [3:0]  pick_idx = 4'd0;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic [3:0]  pairs_found;
    logic [7:0]  moves;
    logic        busy;
    logic        game_done;

    // Small-board instance used for the out-of-range pick index case.
    logic        start12 = 1'b0;
    logic [35:0] face12 = '0;
    logic        pv12 = 1'b0;
    logic [3:0]  pi12 = 4'd0;
    logic [11:0] up12;
    logic [11:0] mt12;
    logic [3:0]  pf12;
    logic [7:0]  mv12;
    logic        busy12;
    logic        done12;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the game.
    localparam int P_IDLE = 0, P_FIRST = 1, P_SECOND = 2, P_SHOW = 3, P_DONE = 4;
    bit m_up[NC];
    bit m_mt[NC];
    int m_face[NC];
    int m_pairs, m_moves, m_timer, m_phase, m_a, m_b;
    bit m_vs;

    card_flip_ctrl #(.N_CARDS(16), .FACE_W(3), .SHOW_FRAMES(60)) dut (
        .pclk(pclk), .rst(rst), .vs_in(vs_in), .start(start), .card_face(card_face),
        .pick_valid(pick_valid), .pick_idx(pick_idx), .face_up(face_up), .matched(matched),
        .pairs_found(pairs_found), .moves(moves), .busy(busy), .game_done(game_done)
    );

    card_flip_ctrl #(.N_CARDS(12), .FACE_W(3), .SHOW_FRAMES(60)) dut12 (
        .pclk(pclk), .rst(rst), .vs_in(vs_in), .start(start12), .card_face(face12),
        .pick_valid(pv12), .pick_idx(pi12), .face_up(up12), .matched(mt12),
        .pairs_found(pf12), .moves(mv12), .busy(busy12), .game_done(done12)
    );

    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack16(input bit v[NC]);
        logic [15:0] r;
        for (int i = 0; i < NC; i++) r[i] = v[i];
        return r;
    endfunction

    // Apply the game rules for one clock edge using the current inputs.
    task automatic model_edge();
        bit tk;
        int i;
        tk = vs_in && !m_vs;
        i  = int'(pick_idx);
        if (rst) begin
            m_vs = 0;
            foreach (m_up[k]) begin m_up[k] = 0; m_mt[k] = 0; m_face[k] = 0; end
            m_pairs = 0; m_moves = 0; m_timer = 0; m_phase = P_IDLE;
        end else begin
            m_vs = vs_in;
            if (start) begin
                foreach (m_up[k]) begin
                    m_up[k] = 0; m_mt[k] = 0; m_face[k] = int'(card_face[k*3 +: 3]);
                end
                m_pairs = 0; m_moves = 0; m_timer = 0; m_phase = P_FIRST;
            end else if ((m_phase == P_FIRST || m_phase == P_SECOND) && pick_valid &&
                         i < NC && !m_up[i] && !m_mt[i]) begin
                if (m_phase == P_FIRST) begin
                    m_up[i] = 1; m_a = i; m_phase = P_SECOND;
                end else begin
                    m_moves = (m_moves < 255) ? m_moves + 1 : 255;
                    m_b = i;
                    if (m_face[m_a] == m_face[i]) begin
                        m_mt[m_a] = 1; m_mt[i] = 1; m_up[m_a] = 0;
                        m_pairs++;
                        m_phase = (m_pairs == NC / 2) ? P_DONE : P_FIRST;
                    end else begin
                        m_up[i] = 1; m_timer = 0; m_phase = P_SHOW;
                    end
                end
            end else if (m_phase == P_SHOW) begin
                if (m_timer == SF) begin
                    m_up[m_a] = 0; m_up[m_b] = 0; m_phase = P_FIRST;
                end else if (tk) begin
                    m_timer++;
                end
            end
        end
    endtask

    task automatic compare_model();
        check_val("face_up", 32'(face_up), 32'(pack16(m_up)));
        check_val("matched", 32'(matched), 32'(pack16(m_mt)));
        check_val("pairs_found", 32'(pairs_found), 32'(m_pairs));
        check_val("moves", 32'(moves), 32'(m_moves));
        check_val("busy", 32'(busy), 32'(m_phase == P_SHOW));
        check_val("game_done", 32'(game_done), 32'(m_phase == P_DONE));
    endtask

    task automatic step();
        model_edge();
        @(posedge pclk);
        #1;
        compare_model();
    endtask

    task automatic do_start(input logic [47:0] f);
        start = 1'b1; card_face = f; step(); start = 1'b0;
    endtask

    task automatic do_pick(input int idx);
        pick_valid = 1'b1; pick_idx = 4'(idx); step(); pick_valid = 1'b0;
    endtask

    task automatic frame();
        vs_in = 1'b1; step(); vs_in = 1'b0; step();
    endtask

    logic [47:0] faces_std;

    initial begin
        // Tile i carries face (i/2 + 3) mod 8: pairs sit on adjacent tiles.
        for (int i = 0; i < NC; i++) faces_std[i*3 +: 3] = 3'((i / 2 + 3) % 8);

        // Reset.
        rst = 1'b1; step(); step();
        rst = 1'b0; step();
        check_val("rst_face_up", 32'(face_up), 32'h0);
        check_val("rst_busy_done", 32'({busy, game_done}), 32'h0);

        // Matching first pair (tiles 0 and 1, face 3).
        do_start(faces_std);
        do_pick(0);
        check_val("first_pick_up0", 32'(face_up[0]), 32'h1);
        do_pick(1);
        check_val("pair01_matched", 32'(matched), 32'h0003);
        check_val("pair01_face_up", 32'(face_up), 32'h0);
        check_val("pair01_pairs", 32'(pairs_found), 32'h1);
        check_val("pair01_moves", 32'(moves), 32'h1);

        // Mismatch 2/5, ignored pick during SHOW, reveal lasts 60 frames.
        do_pick(2);
        do_pick(5);
        check_val("show_busy", 32'(busy), 32'h1);
        check_val("show_up", 32'(face_up), 32'h0024);
        do_pick(7);
        check_val("show_pick_ignored", 32'(face_up), 32'h0024);
        for (int f = 0; f < SF - 1; f++) frame();
        check_val("show_59_up", 32'(face_up), 32'h0024);
        check_val("show_59_busy", 32'(busy), 32'h1);
        frame();
        check_val("show_end_up", 32'(face_up), 32'h0);
        check_val("show_end_busy", 32'(busy), 32'h0);

        // Re-picks of face-up and matched tiles are dropped.
        do_pick(4);
        do_pick(4);
        check_val("repick_up", 32'(face_up), 32'h0010);
        check_val("repick_moves", 32'(moves), 32'h2);
        do_pick(0);
        check_val("pick_matched_up", 32'(face_up), 32'h0010);
        do_pick(5);
        check_val("pair45_matched", 32'(matched), 32'h0033);

        // Out-of-range index on a 12-tile board.
        start12 = 1'b1; face12 = faces_std[35:0]; step(); start12 = 1'b0;
        pv12 = 1'b1; pi12 = 4'd15; step();
        check_val("idx15_up12", 32'(up12), 32'h0);
        check_val("idx15_moves12", 32'(mv12), 32'h0);
        pi12 = 4'd11; step(); pv12 = 1'b0;
        check_val("idx11_up12", 32'(up12), 32'h800);

        // Finish remaining pairs in order.
        for (int p = 1; p < NC / 2; p++) begin
            if (p != 2) begin do_pick(2 * p); do_pick(2 * p + 1); end
        end
        check_val("done_flag", 32'(game_done), 32'h1);
        check_val("done_pairs", 32'(pairs_found), 32'h8);
        check_val("done_matched", 32'(matched), 32'hFFFF);
        do_pick(3);
        check_val("done_pick_ignored", 32'(matched), 32'hFFFF);
        do_start(faces_std);
        check_val("restart_matched", 32'(matched), 32'h0);
        check_val("restart_done", 32'(game_done), 32'h0);
        do_pick(0);
        check_val("restart_first", 32'(face_up), 32'h1);

        // start coincident with a pick: the pick is dropped.
        start = 1'b1; pick_valid = 1'b1; pick_idx = 4'd3; step();
        start = 1'b0; pick_valid = 1'b0;
        check_val("start_pick_up", 32'(face_up), 32'h0);

        // rst during SHOW abandons the game.
        do_pick(2);
        do_pick(5);
        frame(); frame();
        rst = 1'b1; step(); rst = 1'b0;
        check_val("rst_show_up", 32'(face_up), 32'h0);
        check_val("rst_show_busy", 32'(busy), 32'h0);
        check_val("rst_show_moves", 32'(moves), 32'h0);
        do_pick(6);
        check_val("idle_pick_ignored", 32'(face_up), 32'h0);

        // 300 mismatched attempts saturate the move counter.
        do_start(faces_std);
        for (int a = 0; a < 300; a++) begin
            do_pick(2);
            do_pick(5);
            for (int f = 0; f < SF; f++) frame();
        end
        check_val("moves_sat", 32'(moves), 32'd255);

        // Randomized play against the model.
        do_start({$urandom, $urandom});
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 799) == 0);
            start      = ($urandom_range(0, 299) == 0);
            card_face  = {$urandom, $urandom};
            pick_valid = ($urandom_range(0, 2) == 0);
            pick_idx   = 4'($urandom_range(0, 15));
            vs_in      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                card_face = faces_std; start = 1'b1;
            end
            step();
        end
        rst = 1'b0; start = 1'b0; pick_valid = 1'b0; vs_in = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
